bp_fe_bht_updater: RTL



---
 rtl/bp_fe_bht_updater_pkg.sv | 51 +++++
 rtl/bp_fe_bht_update_fifo.sv | 79 +++++++
 rtl/bp_fe_bht_updater.sv | 107 ++++++++++
 3 files changed

// File: rtl/bp_fe_bht_updater_pkg.sv
// Shared types for the BHT write-port updater.
// Provides the processor-config enum, width helpers, and the macros that
// declare the packed BHT update struct and give its total width.

`ifndef BP_FE_BHT_UPDATE_MACROS_SVH
`define BP_FE_BHT_UPDATE_MACROS_SVH

`define BP_FE_DECLARE_BHT_UPDATE_S(idx_w, ghist_w, row_w) \
   typedef struct packed {                                 \
      logic [(idx_w)-1:0]   idx;                           \
      logic [(ghist_w)-1:0] ghist;                         \
      logic [(row_w)-1:0]   val;                           \
      logic                 correct;                       \
   } bp_fe_bht_update_s

`define BP_FE_BHT_UPDATE_WIDTH(idx_w, ghist_w, row_w) ((idx_w) + (ghist_w) + (row_w) + 1)

`endif

package bp_fe_bht_updater_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg = 2'd0,
      e_bp_small_cfg   = 2'd1
   } bp_params_e;

   function automatic int bht_idx_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_small_cfg:   return 6;
         e_bp_default_cfg: return 9;
         default:          return 9;
      endcase
   endfunction

   function automatic int ghist_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_small_cfg:   return 2;
         e_bp_default_cfg: return 2;
         default:          return 2;
      endcase
   endfunction

   function automatic int bht_row_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_small_cfg:   return 8;
         e_bp_default_cfg: return 8;
         default:          return 8;
      endcase
   endfunction

endpackage

// File: rtl/bp_fe_bht_update_fifo.sv
// In-order entry queue for BHT updates: storage, read/write pointers and
// occupancy count. Supports enqueue, dequeue, flush and an in-place
// overwrite of the youngest (tail) entry. Pointers wrap modulo els_p, so
// depths that are not a power of two are supported.

module bp_fe_bht_update_fifo
   #(parameter int els_p       = 4
   , parameter int width_p     = 20
   , parameter int cnt_width_p = $clog2(els_p + 1)
   )
   (input  logic                   clk_i
   , input  logic                   reset_i
   , input  logic                   flush_i
   , input  logic                   enq_i
   , input  logic                   deq_i
   , input  logic                   ovw_i
   , input  logic [width_p-1:0]     data_i
   , output logic [width_p-1:0]     head_o
   , output logic [width_p-1:0]     tail_o
   , output logic [cnt_width_p-1:0] count_o
   , output logic                   empty_o
   , output logic                   full_o
   );

   localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
   localparam logic [cnt_width_p-1:0]  full_cnt_lp = cnt_width_p'(els_p);

   logic [width_p-1:0]      mem_r [els_p];
   logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r, tail_ptr_s;
   logic [cnt_width_p-1:0]  count_r;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      if (p == last_ptr_lp) return {ptr_width_lp{1'b0}};
      else                  return p + ptr_width_lp'(1);
   endfunction

   // Youngest valid entry sits one slot behind the write pointer.
   always_comb begin
      tail_ptr_s = last_ptr_lp;
      if (wr_ptr_r == {ptr_width_lp{1'b0}}) tail_ptr_s = last_ptr_lp;
      else                                  tail_ptr_s = wr_ptr_r - ptr_width_lp'(1);
   end

   // Entry payload storage; contents are don't-care until pointed at, so no reset.
   always_ff @(posedge clk_i) begin
      if (enq_i)
         mem_r[wr_ptr_r] <= data_i;
      else if (ovw_i)
         mem_r[tail_ptr_s] <= data_i;
   end

   // Pointer and occupancy bookkeeping; flush outranks any same-cycle dequeue.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_r <= {ptr_width_lp{1'b0}};
         wr_ptr_r <= {ptr_width_lp{1'b0}};
         count_r  <= {cnt_width_p{1'b0}};
      end else if (flush_i) begin
         rd_ptr_r <= wr_ptr_r;
         count_r  <= {cnt_width_p{1'b0}};
      end else begin
         if (enq_i) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (deq_i) rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({enq_i, deq_i})
            2'b10:   count_r <= count_r + cnt_width_p'(1);
            2'b01:   count_r <= count_r - cnt_width_p'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_o  = mem_r[rd_ptr_r];
   assign tail_o  = mem_r[tail_ptr_s];
   assign count_o = count_r;
   assign empty_o = (count_r == {cnt_width_p{1'b0}});
   assign full_o  = (count_r == full_cnt_lp);

endmodule

// File: rtl/bp_fe_bht_updater.sv
// Producer side of the BHT write port. Buffers resolved-branch updates in a
// small in-order queue and presents the oldest one as a valid/yumi write,
// holding it stable until the BHT takes it. Writes are withheld until the
// BHT init sweep completes, but requests are still queued meanwhile.
// Optional feature: define BP_FE_BHT_UPDATER_MERGE_EN to fold a request with
// the same {idx, ghist} as the tail entry into that entry instead of
// allocating a new one (only when the tail is not the presented head).

module bp_fe_bht_updater
   import bp_fe_bht_updater_pkg::*;
   #(parameter bp_params_e bp_params_p     = e_bp_default_cfg
   , parameter int         els_p           = 4
   , parameter int         bht_idx_width_p = bht_idx_width_f(bp_params_p)
   , parameter int         ghist_width_p   = ghist_width_f(bp_params_p)
   , parameter int         bht_row_width_p = bht_row_width_f(bp_params_p)
   )
   (input  logic                       clk_i
   , input  logic                       reset_i
   , input  logic                       bht_init_done_i
   , input  logic                       flush_i
   , input  logic                       upd_v_i
   , input  logic [bht_idx_width_p-1:0] upd_idx_i
   , input  logic [ghist_width_p-1:0]   upd_ghist_i
   , input  logic [bht_row_width_p-1:0] upd_val_i
   , input  logic                       upd_correct_i
   , output logic                       upd_ready_and_o
   , output logic                       w_v_o
   , output logic [bht_idx_width_p-1:0] w_idx_o
   , output logic [ghist_width_p-1:0]   w_ghist_o
   , output logic [bht_row_width_p-1:0] w_val_o
   , output logic                       w_correct_o
   , input  logic                       w_yumi_i
   , output logic                       empty_o
   );

   `BP_FE_DECLARE_BHT_UPDATE_S(bht_idx_width_p, ghist_width_p, bht_row_width_p);

   localparam int entry_width_lp = `BP_FE_BHT_UPDATE_WIDTH(bht_idx_width_p, ghist_width_p, bht_row_width_p);
   localparam int cnt_width_lp   = $clog2(els_p + 1);
   localparam logic [cnt_width_lp-1:0] one_lp = cnt_width_lp'(1);
   localparam logic [cnt_width_lp-1:0] two_lp = cnt_width_lp'(2);
   // Selects the {idx, ghist} key bits of a packed entry.
   localparam logic [entry_width_lp-1:0] key_mask_lp =
      {{(bht_idx_width_p + ghist_width_p){1'b1}}, {(bht_row_width_p + 1){1'b0}}};

   bp_fe_bht_update_s          upd_s, head_s;
   logic [entry_width_lp-1:0]  head_bits_s, tail_bits_s;
   logic [cnt_width_lp-1:0]    count_s;
   logic                       fifo_empty_s, fifo_full_s;
   logic                       ready_s, accept_s, deq_s;
   logic                       merge_en_s, tail_match_s, merge_ok_s, merge_s, enq_s;

   assign upd_s = '{idx: upd_idx_i, ghist: upd_ghist_i, val: upd_val_i, correct: upd_correct_i};

`ifdef BP_FE_BHT_UPDATER_MERGE_EN
   assign merge_en_s = 1'b1;
`else
   assign merge_en_s = 1'b0;
`endif

   // Handshake, merge qualification and queue strobes.
   always_comb begin
      ready_s      = ~fifo_full_s & ~flush_i;
      accept_s     = upd_v_i & ready_s;
      tail_match_s = (((tail_bits_s ^ upd_s) & key_mask_lp) == {entry_width_lp{1'b0}});
      // The tail may be rewritten only while it is not the write on offer.
      if (count_s >= two_lp)
         merge_ok_s = 1'b1;
      else if (count_s == one_lp)
         merge_ok_s = ~w_v_o;
      else
         merge_ok_s = 1'b0;
      merge_s = merge_en_s & accept_s & tail_match_s & merge_ok_s;
      enq_s   = accept_s & ~merge_s;
      deq_s   = w_yumi_i & w_v_o;
   end

   bp_fe_bht_update_fifo
      #(.els_p       (els_p)
      , .width_p     (entry_width_lp)
      , .cnt_width_p (cnt_width_lp)
      )
      fifo
      (.clk_i   (clk_i)
      , .reset_i (reset_i)
      , .flush_i (flush_i)
      , .enq_i   (enq_s)
      , .deq_i   (deq_s)
      , .ovw_i   (merge_s)
      , .data_i  (upd_s)
      , .head_o  (head_bits_s)
      , .tail_o  (tail_bits_s)
      , .count_o (count_s)
      , .empty_o (fifo_empty_s)
      , .full_o  (fifo_full_s)
      );

   assign head_s          = head_bits_s;
   assign upd_ready_and_o = ready_s;
   assign w_v_o           = ~fifo_empty_s & bht_init_done_i;
   assign w_idx_o         = head_s.idx;
   assign w_ghist_o       = head_s.ghist;
   assign w_val_o         = head_s.val;
   assign w_correct_o     = head_s.correct;
   assign empty_o         = fifo_empty_s;

endmodule
